draw_unit: RTL and testbench

DRAW_UNIT -- requirements
Module: DrawUnit

---
 rtl/draw_unit.sv | 163 ++++++++++++++++
 tb/tb_draw_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/draw_unit.sv
// Bresenham pixel / line / triangle-outline rasteriser emitting one pixel per clock.
// Define DRAWUNIT_TRIANGLE_EN to build triangle support; otherwise CMD[1:0]=3 is a no-op.
module draw_unit (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       ENB,
  input  logic [7:0] CMD,
  input  logic [7:0] P1,
  input  logic [7:0] P2,
  input  logic [7:0] P3,
  input  logic [7:0] P4,
  input  logic [7:0] P5,
  input  logic [7:0] P6,
  output logic [7:0] Xcoord,
  output logic [7:0] Ycoord,
  output logic       Finish
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  state_t state, state_next;

  logic [1:0] op;
  logic [7:0] v1x, v1y, v2x, v2y;
  logic [7:0] cur_x, cur_y, end_x, end_y, dx, dy;
  logic       sx_neg, sy_neg;
  logic signed [10:0] err;

  logic [7:0] seg_x0, seg_y0, seg_x1, seg_y1, abs_x, abs_y;
  logic       is_noop, last_seg, last_pixel, step_x, step_y;
  logic       finish_next, load_pixel;
  logic signed [10:0] e2, dx_s, dy_s, err_next;
  logic       unused_cmd;

  assign unused_cmd = ^CMD[7:2];

`ifdef DRAWUNIT_TRIANGLE_EN
  logic [7:0] v3x, v3y;
  logic [1:0] seg;
`else
  logic unused_ops;
  assign unused_ops = ^{P5, P6};
`endif

  // Pick the end points of the segment currently being set up or drawn.
  always_comb begin
    seg_x0   = v1x;
    seg_y0   = v1y;
    seg_x1   = v2x;
    seg_y1   = v2y;
    last_seg = 1'b1;
    is_noop  = (op == 2'd0);
    if (op == 2'd1) begin
      seg_x1 = v1x;
      seg_y1 = v1y;
    end
`ifdef DRAWUNIT_TRIANGLE_EN
    if (op == 2'd3) begin
      last_seg = (seg == 2'd2);
      case (seg)
        2'd1: begin
          seg_x0 = v2x; seg_y0 = v2y; seg_x1 = v3x; seg_y1 = v3y;
        end
        2'd2: begin
          seg_x0 = v3x; seg_y0 = v3y; seg_x1 = v1x; seg_y1 = v1y;
        end
        default: ;
      endcase
    end
`else
    if (op == 2'd3) is_noop = 1'b1;
`endif
    abs_x = (seg_x1 >= seg_x0) ? seg_x1 - seg_x0 : seg_x0 - seg_x1;
    abs_y = (seg_y1 >= seg_y0) ? seg_y1 - seg_y0 : seg_y0 - seg_y1;
  end

  always_comb begin
    dx_s       = signed'({3'b000, dx});
    dy_s       = signed'({3'b000, dy});
    e2         = signed'({err[9:0], 1'b0});
    step_x     = (e2 >= -dy_s);
    step_y     = (e2 <= dx_s);
    err_next   = err - (step_x ? dy_s : 11'sd0) + (step_y ? dx_s : 11'sd0);
    last_pixel = (cur_x == end_x) && (cur_y == end_y);
  end

  always_comb begin
    state_next  = state;
    finish_next = ENB && (state == DONE);
    load_pixel  = ENB && (state == DRAW);
    case (state)
      IDLE:    if (ENB) state_next = SETUP;
      SETUP:   state_next = is_noop ? DONE : DRAW;
      DRAW:    if (last_pixel) state_next = last_seg ? DONE : SETUP;
      default: state_next = DONE;
    endcase
    if (!ENB) state_next = IDLE;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      Xcoord <= 8'd0;
      Ycoord <= 8'd0;
      Finish <= 1'b0;
    end else begin
      Finish <= finish_next;
      if (load_pixel) begin
        Xcoord <= cur_x;
        Ycoord <= cur_y;
      end
    end
  end

  // Datapath is reloaded at every start, so it needs no reset.
  always_ff @(posedge ACLK) begin
    if (ENB) begin
      case (state)
        IDLE: begin
          op  <= CMD[1:0];
          v1x <= P1;
          v1y <= P2;
          v2x <= P3;
          v2y <= P4;
`ifdef DRAWUNIT_TRIANGLE_EN
          v3x <= P5;
          v3y <= P6;
          seg <= 2'd0;
`endif
        end
        SETUP: begin
          cur_x  <= seg_x0;
          cur_y  <= seg_y0;
          end_x  <= seg_x1;
          end_y  <= seg_y1;
          dx     <= abs_x;
          dy     <= abs_y;
          sx_neg <= (seg_x1 < seg_x0);
          sy_neg <= (seg_y1 < seg_y0);
          err    <= signed'({3'b000, abs_x}) - signed'({3'b000, abs_y});
        end
        DRAW: begin
          if (!last_pixel) begin
            if (step_x) cur_x <= sx_neg ? cur_x - 8'd1 : cur_x + 8'd1;
            if (step_y) cur_y <= sy_neg ? cur_y - 8'd1 : cur_y + 8'd1;
            err <= err_next;
          end
`ifdef DRAWUNIT_TRIANGLE_EN
          else if (!last_seg) begin
            seg <= seg + 2'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_unit.sv
// Scoreboard bench for draw_unit: per-edge expected pixel/Finish entries queued with
// each command and popped one per clock edge for comparison.
module tb_draw_unit;

  logic       ACLK = 1'b0;
  logic       ARESETN, ENB;
  logic [7:0] CMD, P1, P2, P3, P4, P5, P6;
  logic [7:0] Xcoord, Ycoord;
  logic       Finish;

  always #5 ACLK = ~ACLK;

  draw_unit dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ENB(ENB), .CMD(CMD),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6),
    .Xcoord(Xcoord), .Ycoord(Ycoord), .Finish(Finish)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       fin;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] ex_x = 8'd0;
  logic [7:0] ex_y = 8'd0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_pix(input logic [7:0] x, input logic [7:0] y);
    sb.push_back('{x: x, y: y, fin: 1'b0});
    ex_x = x;
    ex_y = y;
  endtask

  task automatic push_hold(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{x: ex_x, y: ex_y, fin: 1'b0});
  endtask

  task automatic push_done(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{x: ex_x, y: ex_y, fin: 1'b1});
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge ACLK); #1;
      e = sb.pop_front();
      check_output({tag, ".xy"}, {16'h0, Xcoord, Ycoord}, {16'h0, e.x, e.y});
      check_output({tag, ".fin"}, {31'h0, Finish}, {31'h0, e.fin});
    end
  endtask

  // Raise ENB for edge 0, then scramble operands to show they were captured.
  task automatic apply_stimulus(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input logic [7:0] e, input logic [7:0] f);
    @(negedge ACLK);
    CMD = cmd; P1 = a; P2 = b; P3 = c; P4 = d; P5 = e; P6 = f;
    ENB = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    CMD = 8'hFF; P1 = 8'hA5; P2 = 8'h5A; P3 = 8'hC3; P4 = 8'h3C; P5 = 8'h99; P6 = 8'h66;
  endtask

  task automatic end_op(input string tag);
    @(negedge ACLK);
    ENB = 1'b0;
    @(posedge ACLK); #1;
    check_output({tag, ".idle_fin"}, {31'h0, Finish}, 32'h0);
    check_output({tag, ".idle_xy"}, {16'h0, Xcoord, Ycoord}, {16'h0, ex_x, ex_y});
  endtask

  initial begin
    ARESETN = 1'b0; ENB = 1'b1;
    CMD = 8'h01; P1 = 8'd10; P2 = 8'd20; P3 = 0; P4 = 0; P5 = 0; P6 = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check_output("reset.xy", {16'h0, Xcoord, Ycoord}, 32'h0);
    check_output("reset.fin", {31'h0, Finish}, 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1; ENB = 1'b0;
    @(posedge ACLK); #1;
    check_output("post_reset.fin", {31'h0, Finish}, 32'h0);
    check_output("post_reset.xy", {16'h0, Xcoord, Ycoord}, 32'h0);

    push_hold(1); push_pix(8'd10, 8'd20); push_done(2);
    apply_stimulus(8'h01, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0);
    drain("pixel"); end_op("pixel");

    push_hold(1);
    for (int i = 0; i <= 3; i++) push_pix(8'(i), 8'd0);
    push_done(2);
    apply_stimulus(8'h02, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0);
    drain("line_h"); end_op("line_h");

    push_hold(1);
    push_pix(8'd5, 8'd5); push_pix(8'd4, 8'd6); push_pix(8'd3, 8'd7); push_pix(8'd2, 8'd8);
    push_done(2);
    apply_stimulus(8'hF6, 8'd5, 8'd5, 8'd2, 8'd8, 8'd0, 8'd0);
    drain("line_diag"); end_op("line_diag");

    push_hold(1);
    push_pix(8'd0, 8'd0); push_pix(8'd1, 8'd1); push_pix(8'd2, 8'd1);
    push_done(2);
    apply_stimulus(8'h02, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0);
    drain("line_shallow"); end_op("line_shallow");

    push_hold(1); push_pix(8'd7, 8'd7); push_done(2);
    apply_stimulus(8'h02, 8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0);
    drain("line_degen"); end_op("line_degen");

    push_hold(1);
    push_pix(8'd255, 8'd255); push_pix(8'd254, 8'd255); push_pix(8'd253, 8'd255);
    push_done(2);
    apply_stimulus(8'h02, 8'd255, 8'd255, 8'd253, 8'd255, 8'd0, 8'd0);
    drain("line_max"); end_op("line_max");

    push_hold(1);
    for (int i = 0; i <= 3; i++) push_pix(8'd255, 8'(i));
    push_done(2);
    apply_stimulus(8'h02, 8'd255, 8'd0, 8'd255, 8'd3, 8'd0, 8'd0);
    drain("line_vert"); end_op("line_vert");

`ifdef DRAWUNIT_TRIANGLE_EN
    push_hold(1);
    push_pix(8'd0, 8'd0); push_pix(8'd1, 8'd0); push_pix(8'd2, 8'd0); push_hold(1);
    push_pix(8'd2, 8'd0); push_pix(8'd1, 8'd1); push_pix(8'd0, 8'd2); push_hold(1);
    push_pix(8'd0, 8'd2); push_pix(8'd0, 8'd1); push_pix(8'd0, 8'd0);
    push_done(2);
`else
    push_hold(1); push_done(2);
`endif
    apply_stimulus(8'h03, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd2);
    drain("triangle"); end_op("triangle");

    push_hold(1); push_done(2);
    apply_stimulus(8'h04, 8'd9, 8'd9, 8'd1, 8'd1, 8'd0, 8'd0);
    drain("noop"); end_op("noop");

    push_hold(1);
    for (int i = 0; i <= 8; i++) push_pix(8'(i), 8'd0);
    apply_stimulus(8'h02, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0);
    drain("abort_run");
    @(negedge ACLK);
    ENB = 1'b0;
    push_hold(2);
    drain("abort_idle");

    push_hold(1);
    for (int i = 0; i <= 200; i++) push_pix(8'(i), 8'd0);
    push_done(1);
    apply_stimulus(8'h02, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0);
    drain("restart"); end_op("restart");

    push_hold(1);
    for (int i = 0; i <= 4; i++) push_pix(8'(i), 8'd0);
    apply_stimulus(8'h02, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0);
    drain("pre_reset");
    @(negedge ACLK);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    check_output("mid_reset.xy", {16'h0, Xcoord, Ycoord}, 32'h0);
    check_output("mid_reset.fin", {31'h0, Finish}, 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1; ENB = 1'b0;
    ex_x = 8'd0; ex_y = 8'd0;
    push_hold(2);
    drain("reset_idle");

    push_hold(1); push_pix(8'd3, 8'd4); push_done(2);
    apply_stimulus(8'h01, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
    drain("after_reset"); end_op("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
